// File: rtl/led_pwm_fader_pkg.sv
// led_pkg: shared constants and types for the LED PWM fader.
//   LED_N          number of LED channels driven by the fader
//   LED_PWM_BITS   default PWM counter width (period = 2^LED_PWM_BITS clocks)
//   LED_STEP_DIV   default clocks per brightness-step tick
//   LED_RISE_STEP  default duty increment per tick while requested on
//   LED_FALL_STEP  default duty decrement per tick while requested off
//   duty_t         duty value at the default PWM width
package led_pkg;

  localparam int LED_N         = 4;
  localparam int LED_PWM_BITS  = 8;
  localparam int LED_STEP_DIV  = 65536;
  localparam int LED_RISE_STEP = 32;
  localparam int LED_FALL_STEP = 4;

  typedef logic [LED_PWM_BITS-1:0] duty_t;

endpackage

// File: rtl/led_pwm_fader_if.sv
// led_pwm_fader_if: groups the fader's LED-side signals.
//   led_req  per-LED on request (from the chaser)
//   led_pwm  registered PWM drive to the LEDs
//   busy     high while any channel is still ramping toward its target
// Modports:
//   master  the chaser/board side: drives led_req, observes led_pwm and busy
//   slave   the fader itself: consumes led_req, drives led_pwm and busy
interface led_pwm_fader_if;
  import led_pkg::*;

  logic [LED_N-1:0] led_req;
  logic [LED_N-1:0] led_pwm;
  logic             busy;

  modport master (output led_req, input led_pwm, input busy);
  modport slave  (input led_req, output led_pwm, output busy);

endinterface

// File: rtl/led_fade_channel.sv
// led_fade_channel: one LED's brightness ramp and PWM comparator.
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   req        registered on-request for this LED
//   tick       one-cycle brightness-step strobe
//   pwm_cnt    shared free-running PWM counter
//   wrap       high in the cycle pwm_cnt is at its maximum
//   led_pwm    registered PWM output bit
//   busy       duty not yet at the target implied by req
// Optional build macro: LED_GAMMA_EN squares the duty before it is used as
// the PWM compare value, giving a perceptually smoother ramp.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS  = LED_PWM_BITS,
  parameter int RISE_STEP = LED_RISE_STEP,
  parameter int FALL_STEP = LED_FALL_STEP
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                wrap,
  output logic                led_pwm,
  output logic                busy
);

  localparam logic [PWM_BITS-1:0] MAX    = '1;
  localparam logic [PWM_BITS:0]   RISE_W = (PWM_BITS+1)'(RISE_STEP);
  localparam logic [PWM_BITS:0]   FALL_W = (PWM_BITS+1)'(FALL_STEP);

  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] shadow;

  // One extra bit of headroom catches the overflow past MAX.
  function automatic logic [PWM_BITS-1:0] sat_add(input logic [PWM_BITS-1:0] d);
    logic [PWM_BITS:0] s;
    s = {1'b0, d} + RISE_W;
    if (s > {1'b0, MAX}) return MAX;
    return s[PWM_BITS-1:0];
  endfunction

  // The extra bit doubles as the borrow flag when the step exceeds duty.
  function automatic logic [PWM_BITS-1:0] sat_sub(input logic [PWM_BITS-1:0] d);
    logic [PWM_BITS:0] s;
    s = {1'b0, d} - FALL_W;
    if (s[PWM_BITS]) return '0;
    return s[PWM_BITS-1:0];
  endfunction

`ifdef LED_GAMMA_EN
  // Square law; MAX is pinned so a fully-on LED stays solidly on.
  function automatic logic [PWM_BITS-1:0] shade(input logic [PWM_BITS-1:0] d);
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
    if (d == MAX) return MAX;
    return sq[2*PWM_BITS-1:PWM_BITS];
  endfunction
`else
  function automatic logic [PWM_BITS-1:0] shade(input logic [PWM_BITS-1:0] d);
    return d;
  endfunction
`endif

  // Stage: duty ramp, advanced only on tick
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      duty <= '0;
    end else if (tick) begin
      duty <= req ? sat_add(duty) : sat_sub(duty);
    end
  end

  // Stage: shadow compare, reloaded only at period end so a period never glitches
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow <= '0;
    end else if (wrap) begin
      shadow <= shade(duty);
    end
  end

  // Stage: PWM output; MAX forces a full-period high instead of MAX-of-(MAX+1)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led_pwm <= 1'b0;
    end else begin
      led_pwm <= (shadow == MAX) ? 1'b1 : (pwm_cnt < shadow);
    end
  end

  assign busy = req ? (duty != MAX) : (duty != '0);

endmodule

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: PWM-fades the chaser's LED pattern so the chase leaves a
// trail. Each LED ramps up while requested and fades out once released.
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   led   led_pwm_fader_if.slave: led_req in, led_pwm and busy out
// Parameters: PWM_BITS (counter width), STEP_DIV (clocks per step tick),
//   RISE_STEP / FALL_STEP (duty change per tick).
// Optional build macro: LED_GAMMA_EN (square-law brightness in each channel).
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int PWM_BITS  = LED_PWM_BITS,
  parameter int STEP_DIV  = LED_STEP_DIV,
  parameter int RISE_STEP = LED_RISE_STEP,
  parameter int FALL_STEP = LED_FALL_STEP
) (
  input  logic           clk,
  input  logic           rstn,
  led_pwm_fader_if.slave led
);

  localparam int                  PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_TOP = PRE_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [LED_N-1:0]    req_q;
  logic [PRE_W-1:0]    prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                wrap;
  logic [LED_N-1:0]    ch_pwm;
  logic [LED_N-1:0]    ch_busy;
  logic                busy;

  assign tick = (prescaler == PRE_TOP);
  assign wrap = (pwm_cnt == MAX);

  // Stage: request capture, step prescaler and PWM counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q     <= '0;
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      req_q     <= led.led_req;
      prescaler <= tick ? '0 : prescaler + PRE_W'(1);
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
    end
  end

  for (genvar i = 0; i < LED_N; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS  (PWM_BITS),
      .RISE_STEP (RISE_STEP),
      .FALL_STEP (FALL_STEP)
    ) u_ch (
      .clk     (clk),
      .rstn    (rstn),
      .req     (req_q[i]),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .wrap    (wrap),
      .led_pwm (ch_pwm[i]),
      .busy    (ch_busy[i])
    );
  end

  // Stage: registered busy summary
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= 1'b0;
    end else begin
      busy <= |ch_busy;
    end
  end

  assign led.led_pwm = ch_pwm;
  assign led.busy    = busy;

endmodule
